// File: rtl/store_buffer_be.sv
// Store path from MEM to the data bus: aligns each store, builds byte enables,
// flags misaligned/illegal stores, queues legal ones and probes loads for word conflicts.
module store_buffer_be #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    localparam int BYTES = DATA_W / 8,
    localparam int OFS   = $clog2(BYTES),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic [2:0]        storeSel,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqData,
    output logic              busValid,
    input  logic              busReady,
    output logic [ADDR_W-1:0] busAddr,
    output logic [DATA_W-1:0] busWdata,
    output logic [BYTES-1:0]  busByteen,
    input  logic              ldValid,
    input  logic [ADDR_W-1:0] ldAddr,
    output logic              ldConflict,
    output logic              excAdES,
    output logic [ADDR_W-1:0] excAddr,
    output logic [PW:0]       count
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // a valid source holds its payload stable until that edge.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [BYTES-1:0]  be_mem   [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;

    logic [OFS-1:0]    ofs;
    logic [7:0]        size;
    logic              illegal;
    logic              misaligned;
    logic              accept, is_store, fault, push, pop;
    logic [BYTES-1:0]  mask;
    logic [BYTES-1:0]  byteen_new;
    logic [DATA_W-1:0] wdata_new;
    logic [ADDR_W-1:0] addr_new;

    assign ofs = reqAddr[OFS-1:0];

    always_comb begin
        size    = 8'd0;
        illegal = 1'b0;
        case (storeSel)
            3'd1: size = 8'd4;
            3'd2: size = 8'd2;
            3'd3: size = 8'd1;
            3'd4: begin
                size    = 8'd8;
                illegal = (DATA_W != 64);
            end
            default: illegal = (storeSel != 3'd0);
        endcase
    end

    assign misaligned = ((8'(ofs) & (size - 8'd1)) != 8'd0);
    assign accept     = reqValid & reqReady;
    assign is_store   = (storeSel != 3'd0);
    assign fault      = accept & is_store & (illegal | misaligned);
    assign push       = accept & is_store & ~illegal & ~misaligned;

    assign busValid = (count != '0);
    assign pop      = busValid & busReady;
    // Ready is withheld while full even if the head leaves this cycle.
    assign reqReady = ~reset & (count != (PW + 1)'(DEPTH));

    assign mask       = BYTES'((16'd1 << size) - 16'd1);
    assign byteen_new = mask << ofs;
    assign wdata_new  = reqData << {ofs, 3'b000};
    assign addr_new   = {reqAddr[ADDR_W-1:OFS], {OFS{1'b0}}};

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= addr_new;
            data_mem[wr_ptr] <= wdata_new;
            be_mem[wr_ptr]   <= byteen_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            excAdES <= 1'b0;
            excAddr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            excAdES <= fault;
            if (fault) excAddr <= reqAddr;
        end
    end

    assign busAddr   = busValid ? addr_mem[rd_ptr] : '0;
    assign busWdata  = busValid ? data_mem[rd_ptr] : '0;
    assign busByteen = busValid ? be_mem[rd_ptr]   : '0;

    // An entry is occupied when its distance from the head is below count.
    logic [PW-1:0] rel;
    logic          hit;
    always_comb begin
        rel = '0;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PW'(i) - rd_ptr;
            if (({1'b0, rel} < count) &&
                (addr_mem[i][ADDR_W-1:OFS] == ldAddr[ADDR_W-1:OFS]))
                hit = 1'b1;
        end
    end

    assign ldConflict = ldValid & hit;

endmodule

// File: tb/tb_store_buffer_be.sv
// Directed bench for store_buffer_be: a queue model of the 32-bit instance is checked
// every cycle, plus literal expectations for both a 32-bit and a 64-bit instance.
module tb_store_buffer_be;

    localparam int DEPTH = 4;
    localparam int E_W   = 32 + 32 + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [2:0]  storeSel = 3'd0;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqData = '0;
    logic        busValid;
    logic        busReady = 1'b0;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busByteen;
    logic        ldValid = 1'b0;
    logic [31:0] ldAddr = '0;
    logic        ldConflict;
    logic        excAdES;
    logic [31:0] excAddr;
    logic [2:0]  count;

    logic        reqValid64 = 1'b0;
    logic        reqReady64;
    logic [2:0]  storeSel64 = 3'd0;
    logic [31:0] reqAddr64 = '0;
    logic [63:0] reqData64 = '0;
    logic        busValid64;
    logic        busReady64 = 1'b0;
    logic [31:0] busAddr64;
    logic [63:0] busWdata64;
    logic [7:0]  busByteen64;
    logic        ldConflict64;
    logic        excAdES64;
    logic [31:0] excAddr64;
    logic [2:0]  count64;

    store_buffer_be #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady), .storeSel(storeSel),
        .reqAddr(reqAddr), .reqData(reqData),
        .busValid(busValid), .busReady(busReady), .busAddr(busAddr),
        .busWdata(busWdata), .busByteen(busByteen),
        .ldValid(ldValid), .ldAddr(ldAddr), .ldConflict(ldConflict),
        .excAdES(excAdES), .excAddr(excAddr), .count(count)
    );

    store_buffer_be #(.DATA_W(64), .ADDR_W(32), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .reset(reset),
        .reqValid(reqValid64), .reqReady(reqReady64), .storeSel(storeSel64),
        .reqAddr(reqAddr64), .reqData(reqData64),
        .busValid(busValid64), .busReady(busReady64), .busAddr(busAddr64),
        .busWdata(busWdata64), .busByteen(busByteen64),
        .ldValid(1'b0), .ldAddr(32'h0), .ldConflict(ldConflict64),
        .excAdES(excAdES64), .excAddr(excAddr64), .count(count64)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // scoreboard: model of the 32-bit buffer, entries packed {addr, data, byteen}
    logic [E_W-1:0] exp_q[$];
    logic           m_exc = 1'b0;
    logic [31:0]    m_exc_addr = '0;

    function automatic bit model_store(input logic [2:0] sel, input logic [31:0] addr,
                                       input logic [31:0] data, output logic [E_W-1:0] e);
        int          size;
        int          o;
        logic [63:0] wide;
        logic [7:0]  be;
        o = int'(addr % 4);
        case (sel)
            3'd1: size = 4;
            3'd2: size = 2;
            3'd3: size = 1;
            default: size = 0;
        endcase
        e = '0;
        if (size == 0 || (o % size) != 0) return 1'b0;
        wide = 64'(data) << (8 * o);
        be   = 8'(((1 << size) - 1) << o);
        e    = {addr - 32'(o), wide[31:0], be[3:0]};
        return 1'b1;
    endfunction

    function automatic bit model_conflict();
        foreach (exp_q[k])
            if ((exp_q[k][E_W-1:36] >> 2) == (ldAddr >> 2)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_exc      <= 1'b0;
            m_exc_addr <= '0;
        end else begin
            automatic int             sz  = exp_q.size();
            automatic bit             acc = reqValid && (sz != DEPTH);
            automatic bit             ok;
            automatic logic [E_W-1:0] e;
            if (sz != 0 && busReady) void'(exp_q.pop_front());
            ok = model_store(storeSel, reqAddr, reqData, e);
            if (acc && storeSel != 3'd0 && ok) exp_q.push_back(e);
            m_exc <= acc && (storeSel != 3'd0) && !ok;
            if (acc && storeSel != 3'd0 && !ok) m_exc_addr <= reqAddr;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("reqReady", 64'(reqReady), 64'(exp_q.size() != DEPTH));
            chk("busValid", 64'(busValid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("busAddr", 64'(busAddr), 64'(exp_q[0][E_W-1:36]));
                chk("busWdata", 64'(busWdata), 64'(exp_q[0][35:4]));
                chk("busByteen", 64'(busByteen), 64'(exp_q[0][3:0]));
            end
            chk("excAdES", 64'(excAdES), 64'(m_exc));
            chk("excAddr", 64'(excAddr), 64'(m_exc_addr));
            chk("ldConflict", 64'(ldConflict), 64'(ldValid && model_conflict()));
        end
    end

    // driver tasks (called just after a rising edge)
    task automatic store(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
        logic ok;
        reqValid = 1'b1;
        storeSel = sel;
        reqAddr  = addr;
        reqData  = data;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            ok = reqReady;
            @(posedge clk);
        end
        #1;
        reqValid = 1'b0;
        storeSel = 3'd0;
        chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        busReady = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        busReady = 1'b0;
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic store64(input logic [2:0] sel, input logic [31:0] addr, input logic [63:0] data);
        reqValid64 = 1'b1;
        storeSel64 = sel;
        reqAddr64  = addr;
        reqData64  = data;
        @(posedge clk);
        #1;
        reqValid64 = 1'b0;
        storeSel64 = 3'd0;
    endtask

    logic [7:0] pat = 8'b1011_0010;

    initial begin
        #2;
        chk("rst_reqReady", 64'(reqReady), 64'd0);
        chk("rst_busValid", 64'(busValid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_excAdES", 64'(excAdES), 64'd0);
        chk("rst_busByteen", 64'(busByteen), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_reqReady", 64'(reqReady), 64'd1);
        @(posedge clk);
        #1;

        // byte store at offset 3, latency from empty, load conflict
        store(3'd3, 32'h1003, 32'h0000_00AB);
        @(negedge clk);
        chk("sb_busValid", 64'(busValid), 64'd1);
        chk("sb_byteen", 64'(busByteen), 64'h8);
        chk("sb_wdata", 64'(busWdata), 64'hAB00_0000);
        chk("sb_addr", 64'(busAddr), 64'h1000);
        ldValid = 1'b1;
        ldAddr  = 32'h1001;
        #1;
        chk("ld_hit", 64'(ldConflict), 64'd1);
        ldAddr = 32'h1004;
        #1;
        chk("ld_miss", 64'(ldConflict), 64'd0);
        ldAddr = 32'h1001;
        @(posedge clk);
        #1;
        drain();
        @(negedge clk);
        chk("ld_after_drain", 64'(ldConflict), 64'd0);
        ldValid = 1'b0;
        @(posedge clk);
        #1;

        // halfword store, then misaligned halfword
        store(3'd2, 32'h2002, 32'h0000_1234);
        @(negedge clk);
        chk("sh_byteen", 64'(busByteen), 64'hC);
        chk("sh_wdata", 64'(busWdata), 64'h1234_0000);
        @(posedge clk);
        #1;
        store(3'd2, 32'h2001, 32'h0000_5678);
        @(negedge clk);
        chk("ades_pulse", 64'(excAdES), 64'd1);
        chk("ades_addr", 64'(excAddr), 64'h2001);
        chk("ades_count", 64'(count), 64'd1);
        @(negedge clk);
        chk("ades_one_cycle", 64'(excAdES), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // no-op, reserved select, dword on a 32-bit bus
        store(3'd0, 32'h5000, 32'h1);
        @(negedge clk);
        chk("noop_count", 64'(count), 64'd0);
        chk("noop_exc", 64'(excAdES), 64'd0);
        @(posedge clk);
        #1;
        store(3'd5, 32'h5004, 32'h2);
        @(negedge clk);
        chk("sel5_exc", 64'(excAdES), 64'd1);
        @(posedge clk);
        #1;
        store(3'd4, 32'h6000, 32'h3);
        @(negedge clk);
        chk("sd32_exc", 64'(excAdES), 64'd1);
        chk("sd32_addr", 64'(excAddr), 64'h6000);
        @(posedge clk);
        #1;

        // fill, stall the fifth request, then release the bus
        for (int i = 0; i < 4; i++) store(3'd1, 32'h4000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
        @(negedge clk);
        chk("full_count", 64'(count), 64'd4);
        chk("full_reqReady", 64'(reqReady), 64'd0);
        @(posedge clk);
        #1;
        fork
            store(3'd1, 32'h4010, 32'hA000_0004);
            begin
                repeat (3) @(negedge clk);
                busReady = 1'b1;
            end
        join
        drain();

        // back-to-back words with a toggling bus and an active load probe
        ldValid = 1'b1;
        ldAddr  = 32'h3008;
        fork
            for (int i = 0; i < 10; i++) store(3'd1, 32'h3000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            for (int c = 0; c < 40; c++) begin
                @(posedge clk);
                #1;
                busReady = pat[c % 8];
            end
        join
        ldValid = 1'b0;
        drain();

        // 64-bit instance
        store64(3'd4, 32'h8, 64'h1122_3344_5566_7788);
        @(negedge clk);
        chk("sd_byteen", 64'(busByteen64), 64'hFF);
        chk("sd_addr", 64'(busAddr64), 64'h8);
        chk("sd_wdata", busWdata64, 64'h1122_3344_5566_7788);
        chk("sd_count", 64'(count64), 64'd1);
        @(posedge clk);
        #1;
        store64(3'd4, 32'hC, 64'h1);
        @(negedge clk);
        chk("sd_mis_exc", 64'(excAdES64), 64'd1);
        chk("sd_mis_addr", 64'(excAddr64), 64'hC);
        chk("sd_mis_count", 64'(count64), 64'd1);
        @(posedge clk);
        #1;
        store64(3'd1, 32'h14, 64'h0000_0000_DEAD_BEEF);
        busReady64 = 1'b1;
        @(posedge clk);
        #1;
        busReady64 = 1'b0;
        @(negedge clk);
        chk("sw64_byteen", 64'(busByteen64), 64'hF0);
        chk("sw64_wdata", busWdata64, 64'hDEAD_BEEF_0000_0000);
        chk("sw64_addr", 64'(busAddr64), 64'h10);
        @(posedge clk);
        #1;

        // reset while entries are draining
        for (int i = 0; i < 3; i++) store(3'd1, 32'h7000 + 32'(4 * i), 32'h7700 + 32'(i));
        @(negedge clk);
        chk("pre_rst_count", 64'(count), 64'd3);
        @(posedge clk);
        #1;
        busReady = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_busValid", 64'(busValid), 64'd0);
        chk("mid_rst_byteen", 64'(busByteen), 64'd0);
        chk("mid_rst_count64", 64'(count64), 64'd0);
        busReady = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_reqReady", 64'(reqReady), 64'd1);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
